// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared NMI state encoding and counter sizing helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} nmi_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser and symmetric debounce filter for one button.
module debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetb,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          flip;

    // fall marks the cycle whose edge commits a 1->0 change of stable
    assign flip  = (sync[1] != stable) && (cnt == LAST);
    assign fall  = flip && !sync[1];
    assign level = stable;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync   <= 2'b11;
            cnt    <= '0;
            stable <= 1'b1;
        end else begin
            sync   <= {sync[0], raw};
            cnt    <= (sync[1] == stable || flip) ? '0 : cnt + 1'b1;
            stable <= flip ? sync[1] : stable;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced button levels, sticky press flags and a paced NMI pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int NMI_PULSE_CYCLES   = 4,
    parameter int NMI_HOLDOFF_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             nmi_en,
    input  logic [WIDTH-1:0] clear_events,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] events,
    output logic             nmib
);

    localparam int TW = cnt_width(NMI_PULSE_CYCLES > NMI_HOLDOFF_CYCLES ?
                                  NMI_PULSE_CYCLES : NMI_HOLDOFF_CYCLES);
    localparam logic [TW-1:0] P_LAST = TW'(NMI_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] H_LAST = TW'(NMI_HOLDOFF_CYCLES - 1);

    logic [WIDTH-1:0] fall;
    nmi_state_t       state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic             pending, pending_n;
    logic             want;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk   (clk),
            .resetb(resetb),
            .raw   (raw_in[i]),
            .level (port_out[i]),
            .fall  (fall[i])
        );
    end

    assign want = (|fall || pending) && nmi_en;

    // A request waiting at the end of holdoff launches straight into the next pulse
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        pending_n = pending;
        case (state)
            IDLE: if (want) begin
                state_n   = PULSE;
                tmr_n     = '0;
                pending_n = 1'b0;
            end
            PULSE: begin
                pending_n = pending | (|fall);
                state_n   = (tmr == P_LAST) ? HOLDOFF : PULSE;
                tmr_n     = (tmr == P_LAST) ? '0 : tmr + 1'b1;
            end
            HOLDOFF: if (tmr == H_LAST && want) begin
                state_n   = PULSE;
                tmr_n     = '0;
                pending_n = 1'b0;
            end else begin
                pending_n = pending | (|fall);
                state_n   = (tmr == H_LAST) ? IDLE : HOLDOFF;
                tmr_n     = (tmr == H_LAST) ? tmr : tmr + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state   <= IDLE;
            tmr     <= '0;
            pending <= 1'b0;
            events  <= '0;
            nmib    <= 1'b1;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            pending <= pending_n;
            events  <= (events & ~clear_events) | fall;
            nmib    <= (state != PULSE);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random traffic against a timestamp reference model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int P = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       resetb;
    logic [7:0] raw_in;
    logic       nmi_en;
    logic [7:0] clear_events;
    logic [7:0] port_out;
    logic [7:0] events;
    logic       nmib;

    button_conditioner #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .NMI_PULSE_CYCLES(P), .NMI_HOLDOFF_CYCLES(H)
    ) dut (
        .clk(clk), .resetb(resetb), .raw_in(raw_in), .nmi_en(nmi_en),
        .clear_events(clear_events), .port_out(port_out), .events(events), .nmib(nmib)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: levels accepted after D consecutive disagreeing samples,
    // NMI tracked as the edge index of the latest fall.
    logic [7:0] m_stable;
    logic [7:0] m_events;
    logic [7:0] raw_q[$];
    logic [7:0] sh[$];
    int cyc = 0;
    int lf;
    bit pend;
    logic prev_nmib = 1'b1;
    int fall_prev = -1;
    int fall_last = -1;
    int nfalls = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = 8'hff;
        m_events = 8'h00;
        raw_q = '{8'hff, 8'hff};
        sh = '{8'hff, 8'hff, 8'hff, 8'hff};
        lf = -1000;
        pend = 1'b0;
    endtask

    task automatic step(input logic [7:0] r, input logic en, input logic [7:0] clr, input logic rb);
        logic [7:0] s, ns, press;
        bit all, busy, go;
        raw_in = r;
        nmi_en = en;
        clear_events = clr;
        resetb = rb;
        @(posedge clk);
        cyc++;
        if (!rb) model_reset();
        else begin
            s = raw_q.pop_front();
            raw_q.push_back(r);
            void'(sh.pop_front());
            sh.push_back(s);
            ns = m_stable;
            for (int b = 0; b < 8; b++) begin
                all = 1'b1;
                foreach (sh[j]) if (sh[j][b] == m_stable[b]) all = 1'b0;
                if (all) ns[b] = ~m_stable[b];
            end
            press = m_stable & ~ns;
            m_stable = ns;
            m_events = (m_events & ~clr) | press;
            busy = (lf <= cyc) && (cyc < lf + P + H);
            go = (cyc >= lf + P + H - 1) && en && (|press || pend);
            if (go) begin
                lf = cyc + 1;
                pend = 1'b0;
            end else if (|press && busy) pend = 1'b1;
        end
        #1;
        check("port_out", port_out, m_stable);
        check("events", events, m_events);
        check("nmib", {7'd0, nmib}, {7'd0, !(lf <= cyc && cyc < lf + P)});
        if (prev_nmib && !nmib) begin
            fall_prev = fall_last;
            fall_last = cyc;
            nfalls++;
        end
        prev_nmib = nmib;
    endtask

    task automatic idle(input int n, input logic en);
        for (int k = 0; k < n; k++) step(8'hff, en, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] r;
        logic en;
        int f0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 1'b1, 8'h00, 1'b0);
            check("rst_port", port_out, 8'hff);
            check("rst_events", events, 8'h00);
            check("rst_nmib", {7'd0, nmib}, 8'd1);
        end
        idle(6, 1'b1);

        // clean press on bit 0: edge e is the e-th edge after raw changes
        for (int e = 0; e <= 10; e++) begin
            step(8'hfe, 1'b1, 8'h00, 1'b1);
            if (e == 5) begin
                check("press_port", port_out, 8'hfe);
                check("press_events", events, 8'h01);
            end
            if (e >= 6 && e <= 9) check("press_low", {7'd0, nmib}, 8'd0);
            if (e == 10) check("press_high", {7'd0, nmib}, 8'd1);
        end
        idle(20, 1'b1);
        step(8'hff, 1'b1, 8'hff, 1'b1);

        // bounce on bit 3, then settle pressed
        f0 = nfalls;
        for (int c = 0; c < 20; c++) step({4'hf, ((c >> 1) & 1) ? 1'b0 : 1'b1, 3'b111}, 1'b1, 8'h00, 1'b1);
        for (int c = 0; c < 30; c++) step(8'hf7, 1'b1, 8'h00, 1'b1);
        check("bounce_pulses", 8'(nfalls - f0), 8'd1);
        idle(20, 1'b1);
        step(8'hff, 1'b1, 8'hff, 1'b1);

        // bit 1 press lands while the bit 0 pulse is low
        for (int c = 0; c < 3; c++) step(8'hfe, 1'b1, 8'h00, 1'b1);
        for (int c = 0; c < 25; c++) step(8'hfc, 1'b1, 8'h00, 1'b1);
        check("gap", 8'(fall_last - fall_prev), 8'd8);
        check("two_events", events, 8'h03);
        step(8'hfc, 1'b1, 8'h01, 1'b1);
        check("clear_one", events, 8'h02);
        idle(20, 1'b1);
        step(8'hff, 1'b1, 8'hff, 1'b1);

        // clear strobe coincident with a new bit 0 press
        for (int e = 0; e <= 5; e++) step(8'hfe, 1'b1, (e == 5) ? 8'h01 : 8'h00, 1'b1);
        check("set_wins", events, 8'h01);
        idle(20, 1'b1);
        step(8'hff, 1'b1, 8'hff, 1'b1);

        // press with NMI disabled, then enable: no pulse
        f0 = nfalls;
        for (int c = 0; c < 10; c++) step(8'h7f, 1'b0, 8'h00, 1'b1);
        check("dis_events", events, 8'h80);
        for (int c = 0; c < 10; c++) step(8'h7f, 1'b1, 8'h00, 1'b1);
        check("dis_pulses", 8'(nfalls - f0), 8'd0);
        idle(20, 1'b1);

        // simultaneous presses: all flags, one pulse
        f0 = nfalls;
        for (int c = 0; c < 20; c++) step(8'hf0, 1'b1, 8'h00, 1'b1);
        check("simul_events", events, 8'h8f);
        check("simul_pulses", 8'(nfalls - f0), 8'd1);
        idle(20, 1'b1);

        // random traffic, including glitches and occasional mid-activity resets
        r = 8'hff;
        en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) r = 8'($urandom);
            if ($urandom_range(0, 49) == 0) en = ~en;
            step(r, en, ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00,
                 $urandom_range(0, 399) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
